// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tour_pkg;

    // Sequencer states: idle passthrough, then issue/await each leg of a knight move.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } tour_state_t;

    // Command opcodes understood by cmd_proc.
    localparam logic [3:0] OP_CAL          = 4'h0;
    localparam logic [3:0] OP_MOVE         = 4'h2;
    localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;
    localparam logic [3:0] OP_START        = 4'h4;

    // Compass headings as carried in the command heading field.
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Response bytes returned over Bluetooth.
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    // Command word layout: opcode, heading, number of squares.
    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    // Pack the three command fields into a 16-bit command word.
    function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
        cmd_t c;
        c.opcode  = op;
        c.heading = hdg;
        c.squares = sq;
        return c;
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Decodes a one-hot knight move into its vertical and horizontal leg commands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows move directly.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd,
    output logic        valid
);

    logic [2:0] sel;

    // Pick the lowest set bit so a multi-hot move still yields one legal knight move.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) begin
                sel = 3'(i);
            end
        end
    end

    // Map the selected move to a vertical leg (plain move) and a horizontal leg (with fanfare).
    always_comb begin
        valid    = |move;
        vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2);
        horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_E, 4'd1);
        case (sel)
            3'd0: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_N, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_E, 4'd1);
            end
            3'd1: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_N, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_W, 4'd1);
            end
            3'd2: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_S, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_W, 4'd2);
            end
            3'd3: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_N, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_W, 4'd2);
            end
            3'd4: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_S, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_W, 4'd1);
            end
            3'd5: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_S, 4'd2);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_E, 4'd1);
            end
            3'd6: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_N, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_E, 4'd2);
            end
            default: begin
                vert_cmd = mk_cmd(OP_MOVE,         HDG_S, 4'd1);
                horz_cmd = mk_cmd(OP_MOVE_FANFARE, HDG_E, 4'd2);
            end
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Command source mux and knight's-tour sequencer in front of cmd_proc.
// Latency: outputs combinational; start_tour/clr_cmd_rdy/send_resp act on the next cycle.
// Backpressure: each leg holds cmd_rdy until clr_cmd_rdy, then waits for send_resp.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    tour_state_t state;
    tour_state_t nxt_state;
    logic [4:0]  nxt_indx;

    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        move_vld;

    tour_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .valid    (move_vld)
    );

    // State and move index are the only registers; reset drops any half-issued leg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            state   <= nxt_state;
            mv_indx <= nxt_indx;
        end
    end

    // Next-state logic plus the command mux; passthrough only while idle.
    always_comb begin
        nxt_state        = state;
        nxt_indx         = mv_indx;
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_ACK;

        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    nxt_indx  = 5'd0;
                    nxt_state = VERT;
                end
            end

            VERT: begin
                cmd = vert_cmd;
                if (!move_vld) begin
                    // Empty tour-memory entry ends the tour early.
                    resp      = RESP_DONE;
                    nxt_state = IDLE;
                end else begin
                    cmd_rdy = 1'b1;
                    if (clr_cmd_rdy) begin
                        nxt_state = WAIT_V;
                    end
                end
            end

            WAIT_V: begin
                cmd = vert_cmd;
                if (send_resp) begin
                    nxt_state = HORZ;
                end
            end

            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) begin
                    nxt_state = WAIT_H;
                end
            end

            WAIT_H: begin
                cmd = horz_cmd;
                if (send_resp) begin
                    if (mv_indx == LAST_IDX) begin
                        // Index parks at the last move; it clears on the next start.
                        resp      = RESP_DONE;
                        nxt_state = IDLE;
                    end else begin
                        nxt_indx  = mv_indx + 5'd1;
                        nxt_state = VERT;
                    end
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;

    logic [7:0]  tour_mem [32];

    int vectors = 0;
    int errors  = 0;
    int legs    = 0;

    // Knight displacement per move bit: +dy is north, +dx is east.
    int dy [8] = '{2, 2, -1, 1, -2, -2, 1, -1};
    int dx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] v;
        logic [15:0] h;
    } vec_t;
    vec_t tbl [12];

    assign move = tour_mem[mv_indx];

    always #10 clk = ~clk;

    tour_cmd #(.NUM_MOVES(24)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference: knight move -> two leg commands built from its displacement.
    task automatic model(input logic [7:0] m, output logic [15:0] v, output logic [15:0] h);
        int b;
        int ay;
        int ax;
        b = 0;
        for (int i = 7; i >= 0; i--) if (m[i]) b = i;
        ay = (dy[b] < 0) ? -dy[b] : dy[b];
        ax = (dx[b] < 0) ? -dx[b] : dx[b];
        v = {4'h2, (dy[b] > 0) ? 8'h00 : 8'h7F, 4'(ay)};
        h = {4'h3, (dx[b] > 0) ? 8'hBF : 8'h3F, 4'(ax)};
    endtask

    task automatic begin_tour();
        start_tour = 1'b1;
        cyc();
        start_tour = 1'b0;
        #1;
        chk("start_idx", mv_indx, 0);
        chk("start_latency", cmd_rdy, 1);
    endtask

    // Drive one leg: random stall (with ignored send_resp/start_tour), clear, wait, respond.
    task automatic leg(input logic [15:0] exp_cmd, input logic [7:0] exp_resp, input bit stop_in_wait);
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            send_resp    = 1'($urandom_range(0, 1));
            start_tour   = 1'($urandom_range(0, 1));
            cmd_rdy_UART = 1'($urandom_range(0, 1));
            #1;
            chk("leg_rdy_held", cmd_rdy, 1);
            chk("leg_cmd", cmd, exp_cmd);
            cyc();
        end
        start_tour   = 1'b0;
        clr_cmd_rdy  = 1'b1;
        cmd_rdy_UART = 1'b1;
        send_resp    = 1'($urandom_range(0, 1));
        #1;
        chk("leg_cmd_clr", cmd, exp_cmd);
        chk("uart_blocked", clr_cmd_rdy_UART, 0);
        cyc();
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        cmd_rdy_UART = 1'b0;
        legs++;
        if (stop_in_wait) return;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            #1;
            chk("wait_rdy_low", cmd_rdy, 0);
            cyc();
        end
        #1;
        chk("wait_rdy_low", cmd_rdy, 0);
        send_resp = 1'b1;
        #1;
        chk("leg_resp", resp, exp_resp);
        cyc();
        send_resp = 1'b0;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_idx", mv_indx, 0);
        chk("rst_cmd", cmd, cmd_UART);
        chk("rst_rdy", cmd_rdy, cmd_rdy_UART);
        chk("rst_resp", resp, 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] h;

        tbl[0]  = '{8'h01, 16'h2002, 16'h3BF1};
        tbl[1]  = '{8'h02, 16'h2002, 16'h33F1};
        tbl[2]  = '{8'h04, 16'h27F1, 16'h33F2};
        tbl[3]  = '{8'h08, 16'h2001, 16'h33F2};
        tbl[4]  = '{8'h10, 16'h27F2, 16'h33F1};
        tbl[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
        tbl[6]  = '{8'h40, 16'h2001, 16'h3BF2};
        tbl[7]  = '{8'h80, 16'h27F1, 16'h3BF2};
        tbl[8]  = '{8'h0C, 16'h27F1, 16'h33F2};
        tbl[9]  = '{8'hC0, 16'h2001, 16'h3BF2};
        tbl[10] = '{8'hFF, 16'h2002, 16'h3BF1};
        tbl[11] = '{8'hA0, 16'h27F2, 16'h3BF1};
        for (int i = 0; i < 32; i++) tour_mem[i] = 8'h01;

        // Reset values while reset is held.
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #5;
        chk("reset_cmd", cmd, 16'h1234);
        chk("reset_rdy", cmd_rdy, 1);
        chk("reset_clr_uart", clr_cmd_rdy_UART, 1);
        chk("reset_resp", resp, 8'hA5);
        chk("reset_idx", mv_indx, 0);
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Idle passthrough.
        cmd_UART     = 16'h2025;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #1;
        chk("pass_cmd", cmd, 16'h2025);
        chk("pass_rdy", cmd_rdy, 1);
        chk("pass_clr", clr_cmd_rdy_UART, 1);
        chk("pass_resp", resp, 8'hA5);
        cyc();
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        chk("pass_clr_low", clr_cmd_rdy_UART, 0);
        chk("pass_rdy_low", cmd_rdy, 0);

        // Decode table, including multi-hot entries.
        for (int t = 0; t < 12; t++) begin
            tour_mem[0] = tbl[t].mv;
            begin_tour();
            leg(tbl[t].v, 8'h5A, 1'b0);
            leg(tbl[t].h, 8'h5A, 1'b0);
            #1;
            chk("idx_after_move", mv_indx, 1);
            do_reset();
        end

        // Randomized full tour against the reference.
        for (int i = 0; i < 24; i++) begin
            tour_mem[i] = 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) tour_mem[i] = tour_mem[i] | 8'($urandom_range(0, 255));
        end
        legs = 0;
        begin_tour();
        for (int i = 0; i < 24; i++) begin
            #1;
            chk("tour_idx", mv_indx, i);
            model(tour_mem[i], v, h);
            leg(v, 8'h5A, 1'b0);
            leg(h, (i == 23) ? 8'hA5 : 8'h5A, 1'b0);
        end
        chk("tour_leg_count", legs, 48);
        cmd_UART     = 16'($urandom);
        cmd_rdy_UART = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("end_idle_cmd", cmd, cmd_UART);
            chk("end_idle_rdy", cmd_rdy, 1);
            chk("end_idle_resp", resp, 8'hA5);
            chk("end_idx_parked", mv_indx, 23);
            cyc();
        end
        cmd_rdy_UART = 1'b0;
        begin_tour();
        do_reset();

        // Empty move entry aborts the tour.
        tour_mem[0] = 8'h40;
        tour_mem[1] = 8'h00;
        begin_tour();
        leg(16'h2001, 8'h5A, 1'b0);
        leg(16'h3BF2, 8'h5A, 1'b0);
        #1;
        chk("abort_rdy", cmd_rdy, 0);
        chk("abort_resp", resp, 8'hA5);
        cyc();
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        #1;
        chk("abort_idle_rdy", cmd_rdy, 1);
        chk("abort_idle_clr", clr_cmd_rdy_UART, 1);
        cyc();
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Asynchronous reset while waiting on the horizontal leg of move 7.
        for (int i = 0; i < 24; i++) tour_mem[i] = 8'(1 << $urandom_range(0, 7));
        begin_tour();
        for (int i = 0; i < 7; i++) begin
            model(tour_mem[i], v, h);
            leg(v, 8'h5A, 1'b0);
            leg(h, 8'h5A, 1'b0);
        end
        model(tour_mem[7], v, h);
        leg(v, 8'h5A, 1'b0);
        #1;
        chk("pre_rst_idx", mv_indx, 7);
        leg(h, 8'h5A, 1'b1);
        cmd_UART = 16'hBEEF;
        #1;
        chk("wait_h_rdy", cmd_rdy, 0);
        do_reset();
        begin_tour();
        model(tour_mem[0], v, h);
        chk("restart_cmd", cmd, v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
